// File: rtl/ifft64_pkg.sv
// rtl/ifft64_pkg.sv - shared IFFT64 widths and output-state encoding
package ifft64_pkg;

   localparam int SAMPLE_W     = 16;
   localparam int FRAME_CYCLES = 32;
   localparam int FRAME_W      = SAMPLE_W * FRAME_CYCLES;
   localparam int ADDR_W       = 10;
   localparam int LANE_W       = $clog2(FRAME_CYCLES);

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } out_state_t;

endpackage

// File: rtl/ifft64_lane_packer.sv
// rtl/ifft64_lane_packer.sv - writes one 16-bit sample into its lane slice of a 512-bit fill buffer
module ifft64_lane_packer
   import ifft64_pkg::*;
(
   input  logic                clk,
   input  logic                we,
   input  logic [LANE_W-1:0]   lane,
   input  logic [SAMPLE_W-1:0] sample,
   output logic [FRAME_W-1:0]  merged
);

   // Every lane is rewritten before a frame completes, so the buffer needs no reset.
   logic [FRAME_W-1:0] fill;

   always_comb begin
      merged = fill;
      merged[int'(lane) * SAMPLE_W +: SAMPLE_W] = sample;
   end

   always_ff @(posedge clk) begin
      if (we) begin
         fill <= merged;
      end
   end

endmodule

// File: rtl/ifft64_output_collector.sv
// rtl/ifft64_output_collector.sv - gathers IFFT sample pairs into 64-point frames and hands them downstream
module ifft64_output_collector #(
   parameter int FRAME_CYCLES = ifft64_pkg::FRAME_CYCLES,
   parameter int ADDR_W       = ifft64_pkg::ADDR_W
) (
   input  logic                            CLK,
   input  logic                            ARST,
   input  logic                            start_check,
   input  logic [ifft64_pkg::SAMPLE_W-1:0] ifft_out0_re,
   input  logic [ifft64_pkg::SAMPLE_W-1:0] ifft_out0_im,
   input  logic [ifft64_pkg::SAMPLE_W-1:0] ifft_out1_re,
   input  logic [ifft64_pkg::SAMPLE_W-1:0] ifft_out1_im,
   input  logic                            out_ready,
   output logic                            out_valid,
   output logic [ifft64_pkg::FRAME_W-1:0]  frame0_re,
   output logic [ifft64_pkg::FRAME_W-1:0]  frame0_im,
   output logic [ifft64_pkg::FRAME_W-1:0]  frame1_re,
   output logic [ifft64_pkg::FRAME_W-1:0]  frame1_im,
   output logic [ADDR_W-1:0]               out_addr,
   output logic                            overflow
);

   import ifft64_pkg::*;

   localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(FRAME_CYCLES - 1);

   logic [LANE_W-1:0]  lane;
   out_state_t         state;
   logic               complete;
   logic               load;
   logic [FRAME_W-1:0] merged0_re;
   logic [FRAME_W-1:0] merged0_im;
   logic [FRAME_W-1:0] merged1_re;
   logic [FRAME_W-1:0] merged1_im;

   assign complete = start_check && (lane == LAST_LANE);
   // A completion is taken only if the holding register is free or being drained this cycle.
   assign load     = complete && ((state == ST_EMPTY) || out_ready);

   ifft64_lane_packer u_pack0_re (
      .clk    (CLK),
      .we     (start_check),
      .lane   (lane),
      .sample (ifft_out0_re),
      .merged (merged0_re)
   );

   ifft64_lane_packer u_pack0_im (
      .clk    (CLK),
      .we     (start_check),
      .lane   (lane),
      .sample (ifft_out0_im),
      .merged (merged0_im)
   );

   ifft64_lane_packer u_pack1_re (
      .clk    (CLK),
      .we     (start_check),
      .lane   (lane),
      .sample (ifft_out1_re),
      .merged (merged1_re)
   );

   ifft64_lane_packer u_pack1_im (
      .clk    (CLK),
      .we     (start_check),
      .lane   (lane),
      .sample (ifft_out1_im),
      .merged (merged1_im)
   );

   always_ff @(posedge CLK or posedge ARST) begin
      if (ARST) begin
         state     <= ST_EMPTY;
         out_valid <= 1'b0;
         overflow  <= 1'b0;
         out_addr  <= '0;
         lane      <= '0;
         frame0_re <= '0;
         frame0_im <= '0;
         frame1_re <= '0;
         frame1_im <= '0;
      end else begin
         if (start_check) begin
            lane <= complete ? '0 : lane + 1'b1;
         end

         if (load) begin
            frame0_re <= merged0_re;
            frame0_im <= merged0_im;
            frame1_re <= merged1_re;
            frame1_im <= merged1_im;
         end

         case (state)
            ST_EMPTY: begin
               if (complete) begin
                  state     <= ST_FULL;
                  out_valid <= 1'b1;
               end
            end
            ST_FULL: begin
               if (complete && out_ready) begin
                  out_addr <= out_addr + 1'b1;
               end else if (complete) begin
                  overflow <= 1'b1;
               end else if (out_ready) begin
                  state     <= ST_EMPTY;
                  out_valid <= 1'b0;
                  out_addr  <= out_addr + 1'b1;
               end
            end
            default: begin
               state     <= ST_EMPTY;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule
